// File: rtl/ga23_tile_fetch_if.sv
// Memory-side bus of the GA23 tile fetcher: tilemap VRAM read port and graphics ROM row port.
// master = fetcher, slave = memory subsystem.
interface ga23_tile_fetch_if #(
  parameter int unsigned ROM_AW = 20
) ();
  logic [15:0]       vram_addr;
  logic [15:0]       vram_data;
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [31:0]       rom_data;

  modport master (
    output vram_addr, rom_req, rom_addr,
    input  vram_data, rom_ack, rom_data
  );

  modport slave (
    input  vram_addr, rom_req, rom_addr,
    output vram_data, rom_ack, rom_data
  );
endinterface

// File: rtl/ga23_tile_fetch.sv
// Per-layer tile fetcher: walks a 64x64 tilemap one 8-pixel cell at a time, fetches the graphics
// row from ROM and hands row/palette/prio/flip to the pixel shifter at every cell boundary.
module ga23_tile_fetch #(
  parameter logic [15:0] MAP_BASE = 16'h0000,
  parameter int unsigned ROM_AW   = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce_pix,
  input  logic                   line_start,
  input  logic [8:0]             line_y,
  input  logic [9:0]             scroll_x,
  input  logic [9:0]             scroll_y,
  ga23_tile_fetch_if.master      bus,
  output logic                   load,
  output logic [31:0]            row,
  output logic [6:0]             palette,
  output logic [1:0]             prio,
  output logic                   reverse,
  output logic [2:0]             offset,
  output logic                   miss
);

  typedef enum logic [2:0] {
    StIdle,
    StCode,
    StAttr,
    StRomReq,
    StWait,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        pix_cnt_q, pix_cnt_d;
  logic [5:0]        col_q, col_d;
  logic [2:0]        offset_q, offset_d;
  logic              miss_q, miss_d;
  logic              ready_q, ready_d;
  logic [15:0]       code_q, code_d;
  logic [6:0]        pal_q, pal_d;
  logic [1:0]        prio_q, prio_d;
  logic              flip_x_q, flip_x_d;
  logic [31:0]       stage_q, stage_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  logic [9:0]  ty;
  logic [5:0]  cell_row;
  logic [2:0]  row_sel;
  logic        boundary;
  logic        word_sel;
  logic [15:0] entry_addr;

  assign ty       = 10'(line_y) + scroll_y;
  assign cell_row = ty[8:3];
  // Attribute word is on vram_data during StRomReq, so flip_y is taken straight from the bus.
  assign row_sel  = ty[2:0] ^ {3{bus.vram_data[10]}};
  assign boundary = ce_pix && (pix_cnt_q == 3'd7);

  assign word_sel   = (state_q == StAttr);
  assign entry_addr = MAP_BASE + {3'b000, cell_row, col_q, word_sel};

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = ce_pix ? pix_cnt_q + 3'd1 : pix_cnt_q;
    col_d      = col_q;
    offset_d   = offset_q;
    miss_d     = miss_q;
    ready_d    = ready_q;
    code_d     = code_q;
    pal_d      = pal_q;
    prio_d     = prio_q;
    flip_x_d   = flip_x_q;
    stage_d    = stage_q;
    rom_addr_d = rom_addr_q;
    load       = 1'b0;

    case (state_q)
      StIdle:   ;
      StCode:   state_d = StAttr;
      StAttr: begin
        code_d  = bus.vram_data;
        state_d = StRomReq;
      end
      StRomReq: begin
        pal_d      = bus.vram_data[6:0];
        flip_x_d   = bus.vram_data[9];
        prio_d     = bus.vram_data[13:12];
        rom_addr_d = ROM_AW'({code_q, row_sel});
        state_d    = StWait;
      end
      StWait: begin
        if (bus.rom_ack) begin
          stage_d = bus.rom_data;
          ready_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold:   ;
      default:  state_d = StIdle;
    endcase

    // A new line overrides everything, including a coincident cell boundary.
    if (line_start) begin
      col_d     = scroll_x[8:3];
      pix_cnt_d = 3'd0;
      offset_d  = scroll_x[2:0];
      miss_d    = 1'b0;
      ready_d   = 1'b0;
      state_d   = StCode;
    end else if (boundary) begin
      load = 1'b1;
      if (!ready_q) begin
        miss_d = 1'b1;
      end
      col_d   = col_q + 6'd1;
      ready_d = 1'b0;
      state_d = StCode;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pix_cnt_q  <= 3'd0;
      col_q      <= 6'd0;
      offset_q   <= 3'd0;
      miss_q     <= 1'b0;
      ready_q    <= 1'b0;
      code_q     <= 16'h0000;
      pal_q      <= 7'h00;
      prio_q     <= 2'd0;
      flip_x_q   <= 1'b0;
      stage_q    <= 32'h0000_0000;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      col_q      <= col_d;
      offset_q   <= offset_d;
      miss_q     <= miss_d;
      ready_q    <= ready_d;
      code_q     <= code_d;
      pal_q      <= pal_d;
      prio_q     <= prio_d;
      flip_x_q   <= flip_x_d;
      stage_q    <= stage_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    bus.vram_addr = 16'h0000;
    if (state_q == StCode || state_q == StAttr) begin
      bus.vram_addr = entry_addr;
    end
  end

  assign bus.rom_req  = (state_q == StWait);
  assign bus.rom_addr = rom_addr_q;

  // Unfetched cells go out transparent rather than showing stale pixels.
  assign row     = ready_q ? stage_q : 32'h0000_0000;
  assign palette = pal_q;
  assign prio    = prio_q;
  assign reverse = flip_x_q;
  assign offset  = offset_q;
  assign miss    = miss_q;

  logic unused_bits;
  assign unused_bits = ^{ty[9], scroll_x[9]};

endmodule

// File: tb/tb_ga23_tile_fetch.sv
// Directed bench for ga23_tile_fetch with a sync VRAM model and a delayed-ack ROM model.
module tb_ga23_tile_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = 9'd0;
  logic [9:0]  scroll_x = 10'd0;
  logic [9:0]  scroll_y = 10'd0;
  logic        load;
  logic [31:0] row;
  logic [6:0]  palette;
  logic [1:0]  prio;
  logic        reverse;
  logic [2:0]  offset;
  logic        miss;

  int n_checks = 0;
  int n_fail   = 0;

  ga23_tile_fetch_if #(.ROM_AW(20)) bus ();

  ga23_tile_fetch #(
    .MAP_BASE(16'h0000),
    .ROM_AW  (20)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .line_start(line_start),
    .line_y    (line_y),
    .scroll_x  (scroll_x),
    .scroll_y  (scroll_y),
    .bus       (bus),
    .load      (load),
    .row       (row),
    .palette   (palette),
    .prio      (prio),
    .reverse   (reverse),
    .offset    (offset),
    .miss      (miss)
  );

  initial forever #5 clk = ~clk;

  // Pixel enable every other clock.
  initial forever begin
    @(posedge clk);
    #1 ce_pix = ~ce_pix;
  end

  logic [15:0] vram [0:65535];
  always @(posedge clk) bus.vram_data <= vram[bus.vram_addr];

  function automatic logic [31:0] rom_word(input logic [19:0] a);
    return 32'hA500_0000 ^ {12'h000, a};
  endfunction

  logic ack_en  = 1'b1;
  logic inj_ack = 1'b0;
  int   ack_delay = 1;
  int   wait_cnt  = 0;

  always @(posedge clk) begin
    bus.rom_ack <= 1'b0;
    if (inj_ack) begin
      bus.rom_ack  <= 1'b1;
      bus.rom_data <= 32'hDEAD_BEEF;
    end else if (bus.rom_req && !bus.rom_ack && ack_en) begin
      if (wait_cnt == ack_delay) begin
        bus.rom_ack  <= 1'b1;
        bus.rom_data <= rom_word(bus.rom_addr);
        wait_cnt     <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  typedef struct {
    logic [31:0] row;
    logic [6:0]  pal;
    logic [1:0]  prio;
    logic        rev;
    logic [19:0] ra;
    int          ce;
  } ld_t;

  ld_t ld_q[$];
  int  ce_since_ls = 0;

  // Records every load and how many pixel enables followed the last line_start.
  always @(negedge clk) begin
    ld_t e;
    #1;
    if (line_start) ce_since_ls = 0;
    else if (ce_pix) ce_since_ls++;
    if (load) begin
      e.row  = row;
      e.pal  = palette;
      e.prio = prio;
      e.rev  = reverse;
      e.ra   = bus.rom_addr;
      e.ce   = ce_since_ls;
      ld_q.push_back(e);
    end
  end

  task automatic pulse_line_start();
    @(negedge clk);
    line_start = 1'b1;
    ld_q.delete();
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_loads(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (ld_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({load, miss, bus.rom_req} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {load, miss, bus.rom_req});
    end
    n_checks++;
    if (row !== 32'h0) begin
      n_fail++; $display("FAIL reset_row: got %h expected 0", row);
    end
    n_checks++;
    if ({palette, prio, reverse, offset} !== 13'h0) begin
      n_fail++; $display("FAIL reset_attr: got %h expected 0", {palette, prio, reverse, offset});
    end
    n_checks++;
    if ({bus.vram_addr, bus.rom_addr} !== 36'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", {bus.vram_addr, bus.rom_addr});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    vram[0] = 16'h0123;
    vram[1] = 16'h1085;
    line_y = 9'd0; scroll_x = 10'd0; scroll_y = 10'd0;
    pulse_line_start();
    wait_loads(1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL basic_timeout: got 0 loads expected 1");
    end else begin
      n_checks++;
      if (ld_q[0].ra !== {1'b0, 16'h0123, 3'd0}) begin
        n_fail++; $display("FAIL basic_rom_addr: got %h expected %h", ld_q[0].ra,
                           {1'b0, 16'h0123, 3'd0});
      end
      n_checks++;
      if (ld_q[0].row !== rom_word({1'b0, 16'h0123, 3'd0})) begin
        n_fail++; $display("FAIL basic_row: got %h expected %h", ld_q[0].row,
                           rom_word({1'b0, 16'h0123, 3'd0}));
      end
      n_checks++;
      if ({ld_q[0].pal, ld_q[0].prio, ld_q[0].rev} !== {7'h05, 2'd1, 1'b0}) begin
        n_fail++; $display("FAIL basic_attr: got %h expected %h",
                           {ld_q[0].pal, ld_q[0].prio, ld_q[0].rev}, {7'h05, 2'd1, 1'b0});
      end
      n_checks++;
      if (ld_q[0].ce !== 8) begin
        n_fail++; $display("FAIL basic_first_load_ce: got %0d expected 8", ld_q[0].ce);
      end
      n_checks++;
      if (miss !== 1'b0) begin
        n_fail++; $display("FAIL basic_miss: got %b expected 0", miss);
      end
    end
  endtask

  task automatic test_flip();
    bit ok;
    vram[0] = 16'h0456;
    vram[1] = 16'h0603;
    line_y = 9'd2;
    pulse_line_start();
    wait_loads(1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL flip_timeout: got 0 loads expected 1");
    end else begin
      n_checks++;
      if (ld_q[0].ra !== {1'b0, 16'h0456, 3'd5}) begin
        n_fail++; $display("FAIL flip_rom_addr: got %h expected %h", ld_q[0].ra,
                           {1'b0, 16'h0456, 3'd5});
      end
      n_checks++;
      if ({ld_q[0].rev, ld_q[0].pal} !== {1'b1, 7'h03}) begin
        n_fail++; $display("FAIL flip_rev_pal: got %h expected %h",
                           {ld_q[0].rev, ld_q[0].pal}, {1'b1, 7'h03});
      end
      n_checks++;
      if (ld_q[0].row !== rom_word({1'b0, 16'h0456, 3'd5})) begin
        n_fail++; $display("FAIL flip_row: got %h expected %h", ld_q[0].row,
                           rom_word({1'b0, 16'h0456, 3'd5}));
      end
    end
  endtask

  task automatic test_scroll_wrap();
    bit ok;
    vram[16'h007E] = 16'h0AAA;
    vram[16'h007F] = 16'h0001;
    vram[0] = 16'h0BBB;
    vram[1] = 16'h0002;
    line_y = 9'd0;
    scroll_x = 10'h3FB;
    pulse_line_start();
    n_checks++;
    if (offset !== 3'd3) begin
      n_fail++; $display("FAIL wrap_offset: got %0d expected 3", offset);
    end
    wait_loads(2, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d loads expected 2", ld_q.size());
    end else begin
      n_checks++;
      if ({ld_q[0].ra, ld_q[0].pal} !== {1'b0, 16'h0AAA, 3'd0, 7'h01}) begin
        n_fail++; $display("FAIL wrap_col63: got %h expected %h", {ld_q[0].ra, ld_q[0].pal},
                           {1'b0, 16'h0AAA, 3'd0, 7'h01});
      end
      n_checks++;
      if ({ld_q[1].ra, ld_q[1].pal} !== {1'b0, 16'h0BBB, 3'd0, 7'h02}) begin
        n_fail++; $display("FAIL wrap_col0: got %h expected %h", {ld_q[1].ra, ld_q[1].pal},
                           {1'b0, 16'h0BBB, 3'd0, 7'h02});
      end
      n_checks++;
      if (ld_q[1].ce !== 16) begin
        n_fail++; $display("FAIL wrap_second_load_ce: got %0d expected 16", ld_q[1].ce);
      end
    end
    scroll_x = 10'd0;
  endtask

  task automatic test_miss();
    bit ok;
    vram[0] = 16'h0123; vram[1] = 16'h1085;
    vram[2] = 16'h0321; vram[3] = 16'h0004;
    vram[4] = 16'h0777; vram[5] = 16'h0006;
    ack_en = 1'b0;
    pulse_line_start();
    wait_loads(1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL miss_timeout: got 0 loads expected 1");
    end else begin
      n_checks++;
      if ({ld_q[0].row, ld_q[0].pal} !== {32'h0, 7'h05}) begin
        n_fail++; $display("FAIL miss_row_pal: got %h expected %h", {ld_q[0].row, ld_q[0].pal},
                           {32'h0, 7'h05});
      end
      @(negedge clk);
      n_checks++;
      if (miss !== 1'b1) begin
        n_fail++; $display("FAIL miss_flag: got %b expected 1", miss);
      end
      // Stray ack while the next cell is still reading the tilemap.
      inj_ack = 1'b1;
      @(negedge clk);
      inj_ack = 1'b0;
      wait_loads(2, ok);
      n_checks++;
      if (!ok || ({ld_q[1].row, ld_q[1].pal} !== {32'h0, 7'h04})) begin
        n_fail++; $display("FAIL miss_late_ack_ignored: got %h expected %h",
                           ok ? {ld_q[1].row, ld_q[1].pal} : 39'h0, {32'h0, 7'h04});
      end
      ack_en = 1'b1;
      wait_loads(3, ok);
      n_checks++;
      if (!ok || (ld_q[2].row !== rom_word({1'b0, 16'h0777, 3'd0})) || (ld_q[2].pal !== 7'h06)) begin
        n_fail++; $display("FAIL miss_recover: got %h expected %h",
                           ok ? ld_q[2].row : 32'h0, rom_word({1'b0, 16'h0777, 3'd0}));
      end
      n_checks++;
      if (miss !== 1'b1) begin
        n_fail++; $display("FAIL miss_sticky: got %b expected 1", miss);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok = 1'b0;
    ack_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rom_req) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || (miss !== 1'b1)) begin
      n_fail++; $display("FAIL rst_pre: got req=%b miss=%b expected req=1 miss=1", ok, miss);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rom_req, load, miss} !== 3'b000) begin
      n_fail++; $display("FAIL rst_async: got %b expected 000", {bus.rom_req, load, miss});
    end
    @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
  endtask

  task automatic test_boundary_line_start();
    bit ok;
    bit seen = 1'b0;
    int n_before;
    vram[0] = 16'h0123; vram[1] = 16'h1085;
    vram[4] = 16'h0999; vram[5] = 16'h0007;
    line_y = 9'd0;
    scroll_x = 10'd0;
    pulse_line_start();
    wait_loads(1, ok);
    // Catch the second boundary and start a new line on top of it.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (load) begin
        seen = 1'b1;
        n_before = ld_q.size();
        line_start = 1'b1;
        scroll_x = 10'h010;
        break;
      end
    end
    n_checks++;
    if (!ok || !seen) begin
      n_fail++; $display("FAIL bls_timeout: got ok=%b seen=%b expected 1 1", ok, seen);
    end else begin
      @(negedge clk);
      line_start = 1'b0;
      n_checks++;
      if (ld_q.size() !== n_before) begin
        n_fail++; $display("FAIL bls_no_load: got %0d loads expected %0d", ld_q.size(), n_before);
      end
      ld_q.delete();
      wait_loads(1, ok);
      n_checks++;
      if (!ok || (ld_q[0].ce !== 8)) begin
        n_fail++; $display("FAIL bls_pix_cnt: got %0d expected 8", ok ? ld_q[0].ce : -1);
      end
      n_checks++;
      if (!ok || ({ld_q[0].ra, ld_q[0].pal} !== {1'b0, 16'h0999, 3'd0, 7'h07})) begin
        n_fail++; $display("FAIL bls_col_reload: got %h expected %h",
                           ok ? {ld_q[0].ra, ld_q[0].pal} : 27'h0, {1'b0, 16'h0999, 3'd0, 7'h07});
      end
      n_checks++;
      if (offset !== 3'd0) begin
        n_fail++; $display("FAIL bls_offset: got %0d expected 0", offset);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) vram[i] = 16'h0000;
    test_reset();
    test_basic();
    test_flip();
    test_scroll_wrap();
    test_miss();
    test_reset_mid_fetch();
    test_boundary_line_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
